// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, one word per line, write-through, no-write-allocate.
// A registered req/ack port to main memory backs misses and stores; stall freezes the front end.
module mem_stage_dcache #(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              hit,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memAck
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} stateT;

    stateT state, nextState;

    logic [LINES-1:0]  validBits;
    logic [TAG_W-1:0]  tagArr  [LINES];
    logic [DATA_W-1:0] dataArr [LINES];

    logic [INDEX_BITS-1:0] curIndex, latIndex;
    logic [TAG_W-1:0]      curTag, latTag;
    logic                  tagMatch, latMatch, ackValid;
    logic                  unusedByteOffset;

    assign curIndex = address[INDEX_BITS+1:2];
    assign curTag   = address[ADDR_W-1:INDEX_BITS+2];
    assign tagMatch = validBits[curIndex] && (tagArr[curIndex] == curTag);

    // The outstanding request address lives in memAddr; stalled inputs are not trusted.
    assign latIndex = memAddr[INDEX_BITS+1:2];
    assign latTag   = memAddr[ADDR_W-1:INDEX_BITS+2];
    assign latMatch = validBits[latIndex] && (tagArr[latIndex] == latTag);

    assign ackValid         = memAck && memReq;
    assign unusedByteOffset = ^address[1:0];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (MemWrite)                 nextState = WRITE;
                else if (MemRead && !tagMatch) nextState = FILL;
            end
            FILL:    if (ackValid) nextState = IDLE;
            WRITE:   if (ackValid) nextState = WDONE;
            WDONE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hit      = 1'b0;
        stall    = 1'b0;
        readData = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    hit   = MemRead && !MemWrite && tagMatch;
                    stall = (MemRead && !tagMatch) || MemWrite;
                    if (hit) readData = dataArr[curIndex];
                end
                FILL, WRITE: stall = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (nextState != IDLE) begin
                        memReq  <= 1'b1;
                        memWe   <= (nextState == WRITE);
                        memAddr <= {address[ADDR_W-1:2], 2'b00};
                        if (nextState == WRITE) memWData <= writeData;
                    end
                end
                FILL, WRITE: if (ackValid) memReq <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          validBits <= '0;
        else if (state == FILL && ackValid) validBits[latIndex] <= 1'b1;
    end

    // NOTE: tag/data arrays carry no reset; the cleared valid bits make their contents irrelevant.
    always_ff @(posedge clk) begin
        if (state == FILL && ackValid) begin
            tagArr[latIndex]  <= latTag;
            dataArr[latIndex] <= memRData;
        end else if (state == WRITE && ackValid && latMatch) begin
            dataArr[latIndex] <= memWData;
        end
    end

endmodule
